// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD bus definitions: arbiter states, HD44780 command codes, long-command test
// Contents:
//   arb_state_e  - arbiter phase encoding (ARB, SETUP, PULSE, HOLD)
//   LCD_CMD_*    - command bytes that need the long execution time
//   LCD_ADDR_*   - DDRAM set-address commands for the two display lines
//   is_long_cmd  - true for clear (8'h01) and home (8'h02/8'h03) command beats
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } arb_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME   = 8'h02;
  localparam logic [7:0] LCD_ADDR_LINE1 = 8'h80;
  localparam logic [7:0] LCD_ADDR_LINE2 = 8'hC0;

  // Return-home ignores bit 0, so 8'h03 is also a home command.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) ||
                   (data == LCD_CMD_HOME) ||
                   (data == (LCD_CMD_HOME | 8'h01)));
  endfunction

endpackage

// File: rtl/lcd_tick_div.sv
// rtl/lcd_tick_div.sv - clock divider producing one-cycle timing ticks
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high
//   clr   in  hold the count at 0 while high
//   tick  out high for one clock when the count equals TICK_DIV-1
module lcd_tick_div #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - two-requester arbiter and write sequencer for an HD44780-style LCD bus
// Optional feature macro: LCD_ARB_LONG_CMD_EN (clear/home command beats use CLEAR_TICKS)
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   req_valid/req_ready  per-requester beat handshake (bit i = requester i)
//   req_rs, req_data     per-requester register select and byte ([8*i+7:8*i])
//   req_last             beat ends the requester's burst and releases the lock
//   lcd_e, lcd_rs,       LCD pins: enable strobe, registered rs/byte of current beat,
//   lcd_rw, lcd_data     rw tied to write
//   owner                one-hot current/locked owner, 0 when unlocked
//   busy                 high whenever a write is in progress
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int E_TICKS     = 1,
  parameter int WRITE_TICKS = 4,
  parameter int CLEAR_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_rs,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic [1:0]  owner,
  output logic        busy
);

  localparam logic [1:0] S_ARB   = ST_ARB;
  localparam logic [1:0] S_SETUP = ST_SETUP;
  localparam logic [1:0] S_PULSE = ST_PULSE;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  // Last phase-counter value of PULSE and HOLD. HOLD covers what is left of
  // the write after one SETUP tick and E_TICKS PULSE ticks.
  localparam logic [7:0] PULSE_LAST  = 8'(E_TICKS - 1);
  localparam logic [7:0] HOLD_LAST_W = 8'(WRITE_TICKS - E_TICKS - 2);
  localparam logic [7:0] HOLD_LAST_C = 8'(CLEAR_TICKS - E_TICKS - 2);

  logic [1:0] state;
  logic [7:0] phase;
  logic       locked;
  logic       last_served;
  logic       long_beat;

  logic       in_arb;
  logic       tick;
  logic [1:0] grant;
  logic       accept;
  logic       sel;
  logic [7:0] beat_data;
  logic       beat_rs;
  logic       beat_last;
  logic       beat_long;
  logic [7:0] hold_last;

  assign in_arb = (state == S_ARB);
  assign busy   = !in_arb;
  assign lcd_rw = 1'b0;

  // Grant is only offered in ARB. A locked owner keeps exclusive access even
  // when it has nothing to send; otherwise the requester not served last wins
  // a tie.
  always_comb begin
    grant = 2'b00;
    if (!reset && in_arb) begin
      if (locked) begin
        grant = owner & req_valid;
      end else if (req_valid == 2'b11) begin
        grant = last_served ? 2'b01 : 2'b10;
      end else begin
        grant = req_valid;
      end
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel       = grant[1];
  assign beat_data = sel ? req_data[15:8] : req_data[7:0];
  assign beat_rs   = req_rs[sel];
  assign beat_last = req_last[sel];

`ifdef LCD_ARB_LONG_CMD_EN
  assign beat_long = is_long_cmd(beat_rs, beat_data);
`else
  assign beat_long = 1'b0;
`endif

  assign hold_last = long_beat ? HOLD_LAST_C : HOLD_LAST_W;

  // Divider runs only during a write and restarts from 0 at every accept.
  lcd_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .clr  (in_arb),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_ARB;
      phase       <= 8'd0;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
      owner       <= 2'b00;
      locked      <= 1'b0;
      last_served <= 1'b1;
      long_beat   <= 1'b0;
    end else begin
      case (state)
        S_ARB: begin
          if (accept) begin
            lcd_rs      <= beat_rs;
            lcd_data    <= beat_data;
            owner       <= grant;
            locked      <= !beat_last;
            last_served <= sel;
            long_beat   <= beat_long;
            phase       <= 8'd0;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tick) begin
            lcd_e <= 1'b1;
            phase <= 8'd0;
            state <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (tick) begin
            if (phase == PULSE_LAST) begin
              lcd_e <= 1'b0;
              phase <= 8'd0;
              state <= S_HOLD;
            end else begin
              phase <= phase + 8'd1;
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            if (phase == hold_last) begin
              phase <= 8'd0;
              state <= S_ARB;
              // The owner survives the write only while its burst holds the lock.
              if (!locked) begin
                owner <= 2'b00;
              end
            end else begin
              phase <= phase + 8'd1;
            end
          end
        end
        default: begin
          lcd_e <= 1'b0;
          phase <= 8'd0;
          state <= S_ARB;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A waiting beat must stay offered until it is accepted.
  for (genvar i = 0; i < 2; i++) begin : g_valid_stable
    a_valid_stable: assert property (@(posedge clk) disable iff (reset)
      (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
  end
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - randomized and directed bench for lcd_bus_arbiter against a timeline model
module tb_lcd_bus_arbiter;

  localparam int TD   = 4;
  localparam int ET   = 1;
  localparam int WT   = 4;
  localparam int CT   = 8;
  localparam int BIG  = 1 << 20;
`ifdef LCD_ARB_LONG_CMD_EN
  localparam int LONG_EXP = CT * TD;
`else
  localparam int LONG_EXP = WT * TD;
`endif

  typedef struct packed {
    logic       last;
    logic       rs;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    int id;
    int cyc;
  } acc_t;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic        lcd_e;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic [1:0]  owner;
  logic        busy;

  lcd_bus_arbiter #(
    .TICK_DIV   (TD),
    .E_TICKS    (ET),
    .WRITE_TICKS(WT),
    .CLEAR_TICKS(CT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_last (req_last),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .owner    (owner),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  beat_t q0[$];
  beat_t q1[$];
  acc_t  acc_log[$];
  logic [1:0] acc_seen = 2'b00;
  logic  mon_en = 1'b0;

  // Reference model: where we are on the timeline of the most recent write.
  int         since;
  int         w_ticks;
  logic       have;
  logic       locked_m;
  int         last_m;
  int         cur_m;
  logic [7:0] cur_data;
  logic       cur_rs;

  logic       exp_busy;
  logic       exp_e;
  logic [1:0] exp_owner;
  logic [1:0] exp_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int beat_ticks(input logic rs, input logic [7:0] d);
`ifdef LCD_ARB_LONG_CMD_EN
    if (!rs && d >= 8'h01 && d <= 8'h03) return CT;
`endif
    return WT;
  endfunction

  function automatic logic [1:0] onehot(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    since    = BIG;
    w_ticks  = WT;
    have     = 1'b0;
    locked_m = 1'b0;
    last_m   = 1;
    cur_m    = 0;
    cur_data = 8'h00;
    cur_rs   = 1'b0;
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc > 80000) begin
      $display("FAIL watchdog got=%0d exp<80000", cyc);
      $fatal(1, "watchdog");
    end
  end

  // Requester driver: presents the head of each queue, pops after acceptance.
  initial begin
    req_valid = 2'b00;
    req_rs    = 2'b00;
    req_data  = 16'h0000;
    req_last  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (acc_seen[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc_seen[1] && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin
        req_valid[0] = 1'b1; req_rs[0] = q0[0].rs; req_data[7:0] = q0[0].data; req_last[0] = q0[0].last;
      end else begin
        req_valid[0] = 1'b0;
      end
      if (q1.size() > 0) begin
        req_valid[1] = 1'b1; req_rs[1] = q1[0].rs; req_data[15:8] = q1[0].data; req_last[1] = q1[0].last;
      end else begin
        req_valid[1] = 1'b0;
      end
    end
  end

  // Monitor: compares every cycle with the model timeline, then advances it.
  always @(negedge clk) begin
    acc_seen = req_valid & req_ready;
    if (mon_en) begin
      if (since < BIG) since = since + 1;
      exp_busy  = have && (since < w_ticks * TD);
      exp_e     = have && (since >= TD) && (since < (1 + ET) * TD);
      exp_owner = (have && (exp_busy || locked_m)) ? onehot(cur_m) : 2'b00;
      check_eq("lcd_e",    32'(lcd_e),    32'(exp_e));
      check_eq("busy",     32'(busy),     32'(exp_busy));
      check_eq("owner",    32'(owner),    32'(exp_owner));
      check_eq("lcd_rw",   32'(lcd_rw),   32'h0);
      check_eq("lcd_data", 32'(lcd_data), 32'(cur_data));
      check_eq("lcd_rs",   32'(lcd_rs),   32'(cur_rs));
      if (exp_busy)                exp_ready = 2'b00;
      else if (locked_m)           exp_ready = onehot(cur_m) & req_valid;
      else if (req_valid == 2'b11) exp_ready = (last_m == 1) ? 2'b01 : 2'b10;
      else                         exp_ready = req_valid;
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      if (exp_ready != 2'b00) begin
        cur_m    = exp_ready[1] ? 1 : 0;
        cur_data = (cur_m == 1) ? req_data[15:8] : req_data[7:0];
        cur_rs   = req_rs[cur_m];
        locked_m = !req_last[cur_m];
        last_m   = cur_m;
        w_ticks  = beat_ticks(cur_rs, cur_data);
        have     = 1'b1;
        since    = -1;
      end
      if (acc_seen != 2'b00) acc_log.push_back('{id: (acc_seen[1] ? 1 : 0), cyc: cyc + 1});
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((q0.size() != 0 || q1.size() != 0 || busy || req_valid != 2'b00) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", 32'(n < budget), 32'h1);
  endtask

  task automatic measure_busy(input string tag, input int exp_len);
    int n;
    int len;
    n = 0;
    len = 0;
    @(negedge clk);
    while (!busy && n < 50) begin @(negedge clk); n++; end
    while (busy && len < 200) begin @(negedge clk); len++; end
    check_eq(tag, 32'(len), 32'(exp_len));
  endtask

  task automatic wait_log(input int count);
    int n;
    n = 0;
    while (acc_log.size() < count && n < 500) begin @(negedge clk); n++; end
    check_eq("log_reached", 32'(acc_log.size() >= count), 32'h1);
  endtask

  initial begin
    int rel;
    int mask;
    int len;
    beat_t b;

    reset = 1'b1;
    model_reset();

    // Both requesters valid during reset; requester 0 must win first afterwards.
    q0.push_back('{last: 1'b1, rs: 1'b1, data: 8'h41});
    q0.push_back('{last: 1'b1, rs: 1'b1, data: 8'h42});
    q1.push_back('{last: 1'b1, rs: 1'b1, data: 8'h61});
    q1.push_back('{last: 1'b1, rs: 1'b0, data: 8'h80});
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_lcd_e",    32'(lcd_e),     32'h0);
      check_eq("rst_lcd_rs",   32'(lcd_rs),    32'h0);
      check_eq("rst_lcd_rw",   32'(lcd_rw),    32'h0);
      check_eq("rst_lcd_data", 32'(lcd_data),  32'h0);
      check_eq("rst_owner",    32'(owner),     32'h0);
      check_eq("rst_busy",     32'(busy),      32'h0);
      check_eq("rst_ready",    32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rel = cyc;
    mon_en = 1'b1;
    wait_idle(2000);
    check_eq("sim_count", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) check_eq("sim_order", 32'(acc_log[i].id), 32'(i % 2));
    if (acc_log.size() > 0) check_eq("first_accept_cycle", 32'(acc_log[0].cyc), 32'(rel + 1));

    // Burst lock: requester 1 sends a line address plus 16 characters.
    acc_log.delete();
    q1.push_back('{last: 1'b0, rs: 1'b0, data: 8'hC0});
    for (int j = 0; j < 16; j++) q1.push_back('{last: (j == 15), rs: 1'b1, data: 8'(8'h30 + j)});
    wait_log(1);
    q0.push_back('{last: 1'b1, rs: 1'b1, data: 8'h5A});
    q0.push_back('{last: 1'b1, rs: 1'b1, data: 8'h5B});
    wait_idle(3000);
    check_eq("burst_count", 32'(acc_log.size()), 32'd19);
    for (int i = 0; i < 19 && i < acc_log.size(); i++) check_eq("burst_order", 32'(acc_log[i].id), 32'((i < 17) ? 1 : 0));

    // Long commands versus the same byte as data.
    q0.push_back('{last: 1'b1, rs: 1'b0, data: 8'h01});
    measure_busy("busy_len_clear", LONG_EXP);
    wait_idle(500);
    q1.push_back('{last: 1'b1, rs: 1'b0, data: 8'h03});
    measure_busy("busy_len_home", LONG_EXP);
    wait_idle(500);
    q0.push_back('{last: 1'b1, rs: 1'b1, data: 8'h01});
    measure_busy("busy_len_data01", WT * TD);
    wait_idle(500);

    // Back-to-back single beats from requester 0.
    acc_log.delete();
    for (int j = 0; j < 4; j++) q0.push_back('{last: 1'b1, rs: 1'b1, data: 8'(8'h70 + j)});
    wait_idle(2000);
    check_eq("b2b_count", 32'(acc_log.size()), 32'd4);
    for (int i = 1; i < 4 && i < acc_log.size(); i++)
      check_eq("b2b_spacing", 32'(acc_log[i].cyc - acc_log[i-1].cyc), 32'(WT * TD + 1));

    // Reset during the enable pulse of a locked burst; requester 1 is starved until then.
    acc_log.delete();
    q0.push_back('{last: 1'b0, rs: 1'b1, data: 8'h55});
    wait_log(1);
    q1.push_back('{last: 1'b1, rs: 1'b1, data: 8'h66});
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!lcd_e && n < 200) begin @(negedge clk); n++; end
      check_eq("pulse_seen", 32'(lcd_e), 32'h1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check_eq("midrst_lcd_e",    32'(lcd_e),    32'h0);
    check_eq("midrst_lcd_data", 32'(lcd_data), 32'h0);
    check_eq("midrst_lcd_rs",   32'(lcd_rs),   32'h0);
    check_eq("midrst_owner",    32'(owner),    32'h0);
    check_eq("midrst_busy",     32'(busy),     32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    rel = cyc;
    model_reset();
    mon_en = 1'b1;
    wait_idle(1000);
    check_eq("midrst_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() >= 2) begin
      check_eq("midrst_winner", 32'(acc_log[1].id), 32'd1);
      check_eq("midrst_accept_cycle", 32'(acc_log[1].cyc), 32'(rel + 1));
    end

    // Randomized traffic: random bursts from one or both requesters.
    for (int r = 0; r < 40; r++) begin
      mask = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        if (mask[i]) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) begin
            b.last = (j == len - 1);
            if ($urandom_range(0, 3) == 0) begin
              b.rs = 1'b0;
              b.data = 8'($urandom_range(1, 3));
            end else begin
              b.rs = 1'($urandom_range(0, 1));
              b.data = 8'($urandom_range(0, 255));
            end
            if (i == 0) q0.push_back(b);
            else q1.push_back(b);
          end
        end
      end
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    wait_idle(30000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
